des_key_round_gen: RTL



---
 rtl/des_key_pkg.sv | 49 ++++
 rtl/des_key_round_gen_if.sv | 32 +++
 rtl/des_pc2.sv | 22 ++
 rtl/des_key_round_gen.sv | 98 +++++++++
 4 files changed

// File: rtl/des_key_pkg.sv
// ============================================================================
// Module   : des_key_pkg
// Purpose  : Shared DES key-schedule tables, round count and FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package des_key_pkg;

    localparam int ROUNDS = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // PC-2 selections, DES 1-based bit numbers into the 56-bit {C,D}
    // (bit 1 is the MSB of C).
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount applied before round k (0-based) in encrypt order.
    localparam int unsigned SHIFT_TAB [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Circular rotation of one 28-bit key half; amt is 0, 1 or 2.
    function automatic logic [27:0] rot28(input logic [27:0] v,
                                          input logic [1:0]  amt,
                                          input logic        left);
        logic [27:0] r;
        r = v;
        case ({left, amt})
            3'b1_01: r = {v[26:0], v[27]};
            3'b1_10: r = {v[25:0], v[27:26]};
            3'b0_01: r = {v[0],    v[27:1]};
            3'b0_10: r = {v[1:0],  v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/des_key_round_gen_if.sv
// ============================================================================
// Module   : des_key_round_gen_if
// Purpose  : Start/key-half inputs and subkey stream outputs of the generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface des_key_round_gen_if;

    logic        Start;
    logic        Decrypt;
    logic [27:0] C0_in;
    logic [27:0] D0_in;
    logic [47:0] Subkey;
    logic        Subkey_valid;
    logic [3:0]  Round;
    logic        Busy;
    logic        Done;

    modport master (
        output Start, Decrypt, C0_in, D0_in,
        input  Subkey, Subkey_valid, Round, Busy, Done
    );

    modport slave (
        input  Start, Decrypt, C0_in, D0_in,
        output Subkey, Subkey_valid, Round, Busy, Done
    );

endinterface

`default_nettype wire

// File: rtl/des_pc2.sv
// ============================================================================
// Module   : des_pc2
// Purpose  : Combinational DES Permuted Choice 2, 56-bit {C,D} to 48-bit key.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_pc2
    import des_key_pkg::*;
(
    input  wire logic [55:0] i_cd,
    output logic      [47:0] o_key
);

    // DES bit n sits at vector position 56-n; output bit 1 lands on bit 47.
    for (genvar i = 0; i < 48; i++) begin : g_pc2_bit
        assign o_key[47-i] = i_cd[56-PC2_TAB[i]];
    end

endmodule

`default_nettype wire

// File: rtl/des_key_round_gen.sv
// ============================================================================
// Module   : des_key_round_gen
// Purpose  : Sequential DES round-key generator, one subkey per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_key_round_gen
    import des_key_pkg::*;
#(
    parameter int ROUNDS = des_key_pkg::ROUNDS
)(
    input  wire logic          Clk,
    input  wire logic          Reset,
    des_key_round_gen_if.slave kif
);

    localparam logic [3:0] c_last_round = 4'(ROUNDS - 1);

    state_e      state_q, state_d;
    logic [27:0] c_reg_q, c_reg_d;
    logic [27:0] d_reg_q, d_reg_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        mode_q,  mode_d;

    logic [3:0]  w_cnt_next;
    logic [1:0]  w_amt;
    logic [1:0]  w_first_amt;
    logic [47:0] w_key;
    logic        w_run;

    assign w_cnt_next = cnt_q + 4'd1;
    // Decrypt walks the schedule backwards with right rotations; the table
    // is symmetric about the single-bit rounds, so the same index applies.
    assign w_amt       = 2'(SHIFT_TAB[w_cnt_next]);
    assign w_first_amt = kif.Decrypt ? 2'd0 : 2'(SHIFT_TAB[0]);
    assign w_run       = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        c_reg_d = c_reg_q;
        d_reg_d = d_reg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (kif.Start) begin
                    c_reg_d = rot28(kif.C0_in, w_first_amt, 1'b1);
                    d_reg_d = rot28(kif.D0_in, w_first_amt, 1'b1);
                    mode_d  = kif.Decrypt;
                    cnt_d   = 4'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q != c_last_round) begin
                    cnt_d   = w_cnt_next;
                    c_reg_d = rot28(c_reg_q, w_amt, ~mode_q);
                    d_reg_d = rot28(d_reg_q, w_amt, ~mode_q);
                end else begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            c_reg_q <= '0;
            d_reg_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_reg_q <= c_reg_d;
            d_reg_q <= d_reg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    des_pc2 u_pc2 (
        .i_cd  ({c_reg_q, d_reg_q}),
        .o_key (w_key)
    );

    assign kif.Subkey       = w_run ? w_key : 48'd0;
    assign kif.Subkey_valid = w_run;
    assign kif.Round        = w_run ? cnt_q : 4'd0;
    assign kif.Busy         = w_run;
    assign kif.Done         = w_run && (cnt_q == c_last_round);

endmodule

`default_nettype wire
